// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch port (IF) and the MEM-stage load/store port (D).
// A granted request is latched into the registered RAM outputs, sequenced
// across RAM_LAT read cycles, and returned to its owner with a 1-cycle ack.
module mem_port_arbiter #(
  parameter int RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  output logic        if_stall_o,
  input  logic        flush_i,
  input  logic        d_ce_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_data_i,
  output logic [31:0] d_data_o,
  output logic        d_ack_o,
  output logic        d_stall_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_bad_lat
    $error("mem_port_arbiter: RAM_LAT must be 1..3");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  localparam logic       OWN_IF = 1'b0;
  localparam logic       OWN_D  = 1'b1;
  localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;       // 1 = D port owns the transaction
  logic        we_q, we_d;             // latched is_write
  logic [1:0]  cnt_q, cnt_d;
  logic        last_q, last_d;         // last granted port
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  // The registered RAM outputs double as the latched request: they are
  // loaded at grant, held through WAIT and cleared on the way to ACK/IDLE.
  logic        ram_ce_q, ram_ce_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [3:0]  ram_sel_q, ram_sel_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;

  logic if_req, gnt_d, gnt_if, if_flush, clr;

  assign if_req   = if_ce_i & ~flush_i;
  assign gnt_d    = d_ce_i & (~if_req | (last_q == OWN_IF));
  assign gnt_if   = if_req & (~d_ce_i | (last_q == OWN_D));
  assign if_flush = (owner_q == OWN_IF) & flush_i;

  // Next-state, grant and registered-output computation
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    ram_ce_d    = 1'b0;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_sel_d   = ram_sel_q;
    ram_wdata_d = ram_wdata_q;
    clr         = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_d | gnt_if) begin
          state_d     = ACCESS;
          owner_d     = gnt_d;
          last_d      = gnt_d;
          we_d        = gnt_d & d_we_i;
          ram_ce_d    = 1'b1;
          ram_we_d    = gnt_d & d_we_i;
          ram_addr_d  = gnt_d ? d_addr_i : if_addr_i;
          ram_sel_d   = gnt_d ? d_sel_i  : 4'hF;
          ram_wdata_d = gnt_d ? d_data_i : 32'h0;
        end
      end
      ACCESS: begin
        if (if_flush) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else if (we_q || RAM_LAT == 1) begin
          state_d  = ACK;
          clr      = 1'b1;
          if_ack_d = (owner_q == OWN_IF);
          d_ack_d  = (owner_q == OWN_D);
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end
      end
      WAIT: begin
        if (if_flush) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else if (cnt_q == 2'd1) begin
          state_d  = ACK;
          clr      = 1'b1;
          if_ack_d = (owner_q == OWN_IF);
          d_ack_d  = (owner_q == OWN_D);
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: begin
        state_d = IDLE;
        clr     = 1'b1;
      end
    endcase
    if (clr) begin
      ram_we_d    = 1'b0;
      ram_addr_d  = 32'h0;
      ram_sel_d   = 4'h0;
      ram_wdata_d = 32'h0;
    end
  end

  // State and output registers; reset aborts any transaction without ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      cnt_q       <= 2'd0;
      last_q      <= OWN_IF;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 32'h0;
      ram_sel_q   <= 4'h0;
      ram_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_sel_q   <= ram_sel_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // A flush arriving in the ACK cycle still kills the fetch ack
  assign if_ack_o   = if_ack_q & ~flush_i;
  assign if_data_o  = if_ack_o ? ram_data_i : 32'h0;
  assign d_ack_o    = d_ack_q;
  assign d_data_o   = (d_ack_q & ~we_q) ? ram_data_i : 32'h0;
  assign if_stall_o = if_ce_i & ~if_ack_o & ~flush_i;
  assign d_stall_o  = d_ce_i & ~d_ack_o;

  assign ram_ce_o   = ram_ce_q;
  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_sel_o  = ram_sel_q;
  assign ram_data_o = ram_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch port (IF) and the load/store port of the MEM stage (D).
- Latches the winning request, sequences the RAM access across the configured read latency, and returns data with a one-cycle ack.
- Drives per-port stall requests into the pipeline stall controller.
- Sits between the IF/MEM stages and the RAM, replacing their direct RAM connections.

Parameters:
- RAM_LAT, 1, RAM read latency in cycles: ram_data_i is valid RAM_LAT cycles after the cycle in which ram_ce_o=1. Legal range 1..3; any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_ce_i  in  1  fetch request; held stable until if_ack_o
- if_addr_i  in  32  fetch word address
- if_data_o  out  32  fetched instruction, valid only while if_ack_o=1
- if_ack_o  out  1  fetch complete, one-cycle pulse
- if_stall_o  out  1  stall request to IF
- flush_i  in  1  exception flush; cancels IF transactions only
- d_ce_i  in  1  data request; held stable until d_ack_o
- d_we_i  in  1  1=write, 0=read
- d_addr_i  in  32  data address
- d_sel_i  in  4  byte enables
- d_data_i  in  32  store data
- d_data_o  out  32  load data, valid only while d_ack_o=1
- d_ack_o  out  1  data access complete, one-cycle pulse
- d_stall_o  out  1  stall request to MEM
- ram_ce_o  out  1  RAM chip enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  32  RAM address
- ram_sel_o  out  4  RAM byte enables
- ram_data_o  out  32  RAM write data
- ram_data_i  in  32  RAM read data

Behaviour:
- States: IDLE, ACCESS, WAIT, ACK.
- Registers: owner (IF/D), is_write, latched addr/sel/wdata, 2-bit latency counter, last_grant.

Reset:
- rst=1 at a clock edge puts the block in IDLE, last_grant=IF, and counter=0.
- From the following cycle, every output is 0.
- Reset in any state aborts the transaction with no ack. A write in ACCESS at that edge is still committed by the RAM.

IDLE:
- Grant rules:
  - d_ce_i only: grant D.
  - if_ce_i and flush_i=0 only: grant IF.
  - Both: grant the port not equal to last_grant.
- On a grant: latch the request, set owner, update last_grant, go to ACCESS.
- An IF grant latches we=0 and sel=1111.

ACCESS (1 cycle):
- ram_ce_o=1; ram_we_o/addr/sel/data come from the latched values.
- Write: go to ACK; RAM_LAT is ignored.
- Read with RAM_LAT=1: go to ACK.
- Read with RAM_LAT>1: load counter=RAM_LAT-1 and go to WAIT.

WAIT:
- ram_ce_o=0; other ram_* outputs hold.
- Decrement the counter; go to ACK when it reaches 1.

ACK (1 cycle):
- Owner's ack_o=1.
- Read: owner's data_o = ram_data_i, combinational pass-through.
- Next state is always IDLE. The arbiter does not sample requests in ACK, so the held request is never served twice.

Datapath outputs:
- ram_* outputs are registered and are 0 in IDLE and ACK.
- if_data_o and d_data_o are 0 whenever the corresponding ack is 0.

Latency, counted from request seen in IDLE at cycle T:
- Read ack at T+1+RAM_LAT.
- Write ack at T+2.

Stalls:
- if_stall_o = if_ce_i & ~if_ack_o & ~flush_i.
- d_stall_o = d_ce_i & ~d_ack_o.
- Both are combinational, so a waiting (non-granted) port stalls.

Flush:
- flush_i=1 while owner=IF in ACCESS or WAIT: go to IDLE next cycle, no if_ack_o, and last_grant stays IF.
- flush_i=1 while owner=IF in ACK: ack is suppressed.
- D transactions are unaffected by flush_i.

Edge cases:
- d_we_i=1 with d_sel_i=0000 is a normal write, acked with sel 0000.
- Requests dropped before ack are not cancelled; the latched transaction completes and acks into a port that no longer waits. The pipeline must not drop requests.

Test Plan:
- RAM_LAT=1, D read only at 0x100 (RAM word 0xDEADBEEF): ram_ce_o=1 at T+1, d_ack_o=1 with d_data_o=0xDEADBEEF at T+2, d_stall_o=1 at T..T+1.
- RAM_LAT=3, IF read at 0x0: ram_ce_o high only at T+1, if_ack_o at T+4, if_stall_o 1 for T..T+3.
- After reset, IF and D request at the same cycle: D served first (write 0x12345678, sel 1111), IF acked at T+5 (RAM_LAT=1). Repeat with both still requesting: IF wins next, then alternate.
- RAM_LAT=2, IF read in WAIT, flush_i=1 for one cycle: no if_ack_o, IDLE next cycle, a pending D request is granted the following cycle.
- D write sel=0010 data 0x0000AB00: ram_we_o=1, ram_sel_o=0010 for exactly one cycle, ack at T+2 independent of RAM_LAT=3.
- rst asserted in WAIT: all outputs 0 next cycle, no ack, and the next request is handled normally.
